out_stream_packer: RTL and testbench
====================================

OUT_STREAM_PACKER -- requirements
Module: out_stream_packer

Interface
REQ-001 Parameter col, default 8, number of output channels per OFIFO vector.
REQ-002 Parameter psum_bw, default 16, width of one channel psum.
REQ-003 Parameter out_bw, default 32, stream beat width; SHALL be a multiple of psum_bw that divides col*psum_bw.
REQ-004 Parameter BEATS, derived, (col*psum_bw)/out_bw (default 4).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_data  input  col*psum_bw  head entry of upstream OFIFO; channel c at bits [psum_bw*c +: psum_bw].
REQ-008 in_valid  input  1  OFIFO non-empty; in_data valid.
REQ-009 in_rd  output  1  one-cycle pop strobe to OFIFO.
REQ-010 relu_en  input  1  clamp negative signed channels to 0 before packing.
REQ-011 frame_len  input  8  vectors per frame; 0 means 256.
REQ-012 m_data  output  out_bw  stream beat.
REQ-013 m_valid  output  1  beat valid.
REQ-014 m_ready  input  1  downstream accepts beat.
REQ-015 m_last  output  1  final beat of a frame.
REQ-016 frame_done  output  1  one-cycle pulse after final beat of a frame is accepted.

Function
REQ-017 FSM states: IDLE, SEND; in_rd SHALL be asserted only when the capture register is free (IDLE, or SEND final beat accepted this cycle) and in_valid=1.
REQ-018 On a pop cycle, in_data SHALL be captured (after optional ReLU) into a col*psum_bw hold register; next state SEND, beat index 0.
REQ-019 ReLU: channel value with MSB=1 becomes 0 when relu_en=1; otherwise passed unchanged; relu_en sampled on the pop cycle.
REQ-020 In SEND, m_valid=1 and m_data = hold[out_bw*beat +: out_bw]; beat advances only on m_valid&m_ready.
REQ-021 m_data/m_valid/m_last SHALL remain stable while m_valid=1 and m_ready=0.
REQ-022 After beat BEATS-1 is accepted: if in_valid=1, pop and capture the next vector in the same cycle (no bubble); else go to IDLE with m_valid=0.
REQ-023 Latency: first beat appears on m_data the cycle after the pop cycle.
REQ-024 Vector counter counts vectors completed within the frame; frame_len latched when the counter is 0 at a pop.
REQ-025 m_last=1 only on beat BEATS-1 of vector (latched frame_len - 1).
REQ-026 On acceptance of an m_last beat: counter returns to 0, frame_done pulses next cycle.
REQ-027 frame_len changes mid-frame SHALL have no effect until the next frame.
REQ-028 in_valid deasserting mid-frame SHALL leave the counter intact; the frame resumes on the next pop.

Reset
REQ-029 Reset asserted at any time SHALL immediately force IDLE, beat=0, counter=0, hold=0, and in_rd=0, m_valid=0, m_last=0, frame_done=0, m_data=0.
REQ-030 A beat in flight at reset is discarded; no partial-vector or frame state survives.
REQ-031 First pop may occur on the first clock edge after reset deasserts.

Structure
REQ-032 Shared package holds state encoding (IDLE, SEND) and defaults COL=8, PSUM_BW=16, OUT_BW=32.
REQ-033 One sub-module, psum_relu, SHALL implement per-channel ReLU combinationally on the full vector.
REQ-034 Block sits directly downstream of the core's OFIFO port: in_data<-OFIFO output, in_valid<-ofifo_valid, in_rd->OFIFO read.

Verification
REQ-035 Single vector, channels 0..7 = 1..8, m_ready=1, frame_len=1 -> in_rd one cycle; beats 0x00020001, 0x00040003, 0x00060005, 0x00080007; m_last on beat 4; frame_done next cycle.
REQ-036 relu_en=1, ch0=0xFFFF, ch1=0x0005 -> beat0 = 0x00050000; relu_en=0 -> beat0 = 0x0005FFFF.
REQ-037 Backpressure: m_ready toggling 1,0,0,1 during beats -> each beat held stable, exactly 4 accepted beats, no in_rd until final beat accepted.
REQ-038 frame_len=3, 3 vectors queued, m_ready=1 -> 12 contiguous beats, no bubble, m_last only on beat 12, one frame_done.
REQ-039 frame_len=0 -> m_last on beat 1024 only.
REQ-040 Reset asserted during beat 2 of vector 1 of a 2-vector frame -> outputs 0 immediately; next frame's m_last counts from vector 0.

Source files
------------

// File: rtl/out_stream_packer_pkg.sv
// -----------------------------------------------------------------------------
// out_stream_packer_pkg
// Shared definitions for the OFIFO-to-stream packer:
//   - packer FSM state encoding (IDLE, SEND)
//   - default geometry: COL channels of PSUM_BW bits, packed into OUT_BW beats
// -----------------------------------------------------------------------------
package out_stream_packer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int OUT_BW  = 32;

endpackage : out_stream_packer_pkg

// File: rtl/out_stream_packer_psum_relu.sv
// -----------------------------------------------------------------------------
// psum_relu
// Combinational per-channel ReLU over a full OFIFO vector. A channel whose
// sign bit is set is replaced by zero when relu_en_i is high; otherwise the
// vector passes through unchanged.
// Ports:
//   relu_en_i  enable clamping of negative channels
//   data_i     col*psum_bw input vector, channel c at [psum_bw*c +: psum_bw]
//   data_o     col*psum_bw clamped vector, same layout
// -----------------------------------------------------------------------------
module psum_relu
    import out_stream_packer_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW
) (
    input  logic                   relu_en_i,
    input  logic [col*psum_bw-1:0] data_i,
    output logic [col*psum_bw-1:0] data_o
);

    // Clamp each negative channel to zero when enabled
    always_comb begin
        data_o = data_i;
        for (int c = 0; c < col; c++) begin
            if (relu_en_i && data_i[psum_bw*c + psum_bw - 1]) begin
                data_o[psum_bw*c +: psum_bw] = {psum_bw{1'b0}};
            end else begin
                data_o[psum_bw*c +: psum_bw] = data_i[psum_bw*c +: psum_bw];
            end
        end
    end

endmodule : psum_relu

// File: rtl/out_stream_packer.sv
// -----------------------------------------------------------------------------
// out_stream_packer
// Pops psum vectors from the upstream OFIFO, optionally applies ReLU, and
// emits each vector as BEATS consecutive out_bw-wide stream beats with
// valid/ready handshaking. Vectors are grouped into frames of frame_len
// vectors (0 = 256); m_last marks the final beat of a frame and frame_done
// pulses the cycle after that beat is accepted.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_data/in_valid      OFIFO head entry and non-empty flag
//   in_rd                 one-cycle OFIFO pop strobe
//   relu_en               clamp negative channels (sampled on pop)
//   frame_len             vectors per frame (latched at frame start)
//   m_data/m_valid/m_last stream beat, valid, frame-final marker
//   m_ready               downstream accept
//   frame_done            pulse after the frame-final beat is accepted
// -----------------------------------------------------------------------------
module out_stream_packer
    import out_stream_packer_pkg::*;
#(
    parameter  int col     = COL,
    parameter  int psum_bw = PSUM_BW,
    parameter  int out_bw  = OUT_BW,
    localparam int BEATS   = (col*psum_bw)/out_bw
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_rd,
    input  logic                   relu_en,
    input  logic [7:0]             frame_len,
    output logic [out_bw-1:0]      m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   frame_done
);

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [8:0]             len_q, len_d;
    logic [col*psum_bw-1:0] hold_q, hold_d;
    logic                   frame_done_q, frame_done_d;

    logic                   [col*psum_bw-1:0] relu_data_s;
    logic                   accept_s;
    logic                   last_beat_s;
    logic                   last_vec_s;
    logic                   vec_done_s;
    logic                   pop_s;

    psum_relu #(
        .col     (col),
        .psum_bw (psum_bw)
    ) u_psum_relu (
        .relu_en_i (relu_en),
        .data_i    (in_data),
        .data_o    (relu_data_s)
    );

    // Handshake qualifiers; the hold register is free in IDLE or when its final beat leaves now
    always_comb begin
        accept_s    = (state_q == ST_SEND) && m_ready;
        last_beat_s = (beat_q == BEAT_W'(BEATS - 1));
        last_vec_s  = ({1'b0, cnt_q} == (len_q - 9'd1));
        vec_done_s  = accept_s && last_beat_s;
        pop_s       = !reset && in_valid && ((state_q == ST_IDLE) || vec_done_s);
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (vec_done_s && !pop_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: beat index, frame counter, frame length latch, hold register
    always_comb begin
        beat_d       = beat_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        hold_d       = hold_q;
        frame_done_d = 1'b0;

        if (vec_done_s) begin
            beat_d = {BEAT_W{1'b0}};
            if (last_vec_s) begin
                cnt_d        = 8'd0;
                frame_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (accept_s) begin
            beat_d = beat_q + BEAT_W'(1);
        end else begin
            beat_d = beat_q;
        end

        // cnt_d (not cnt_q) decides frame start, so a back-to-back pop right
        // after a frame-final beat still latches the new frame's length
        if (pop_s) begin
            hold_d = relu_data_s;
            beat_d = {BEAT_W{1'b0}};
            if (cnt_d == 8'd0) begin
                len_d = (frame_len == 8'd0) ? 9'd256 : {1'b0, frame_len};
            end else begin
                len_d = len_q;
            end
        end else begin
            hold_d = hold_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q       <= {BEAT_W{1'b0}};
            cnt_q        <= 8'd0;
            len_q        <= 9'd0;
            hold_q       <= {(col*psum_bw){1'b0}};
            frame_done_q <= 1'b0;
        end else begin
            beat_q       <= beat_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            hold_q       <= hold_d;
            frame_done_q <= frame_done_d;
        end
    end

    // FSM outputs, decoded from registered state only (except the pop strobe)
    always_comb begin
        in_rd      = pop_s;
        frame_done = frame_done_q;
        if (state_q == ST_SEND) begin
            m_valid = 1'b1;
            m_data  = hold_q[out_bw*beat_q +: out_bw];
            m_last  = last_beat_s && last_vec_s;
        end else begin
            m_valid = 1'b0;
            m_data  = {out_bw{1'b0}};
            m_last  = 1'b0;
        end
    end

endmodule : out_stream_packer

// File: tb/tb_out_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_out_stream_packer
// Directed bench for out_stream_packer. An OFIFO model feeds vectors; each
// observed pop pushes the expected beats (ReLU + frame position from a small
// frame model) into a scoreboard that is compared against every valid beat.
// -----------------------------------------------------------------------------
module tb_out_stream_packer;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int OUT_BW  = 32;
    localparam int BEATS   = 4;
    localparam int VW      = COL*PSUM_BW;

    logic              clk;
    logic              reset;
    logic [VW-1:0]     in_data;
    logic              in_valid;
    logic              in_rd;
    logic              relu_en;
    logic [7:0]        frame_len;
    logic [OUT_BW-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              frame_done;

    int nvec = 0;
    int nerr = 0;

    logic [VW-1:0]     fifo[$];
    logic [OUT_BW:0]   sb[$];
    logic [OUT_BW-1:0] log_d[$];
    logic              log_last[$];
    int                log_t[$];
    int                nlast = 0;
    int                nfd   = 0;
    int                cyc   = 0;
    int                mcnt  = 0;
    int                mlen  = 1;
    logic              exp_fd = 1'b0;
    logic              do_pop = 1'b0;

    out_stream_packer #(
        .col     (COL),
        .psum_bw (PSUM_BW),
        .out_bw  (OUT_BW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_rd      (in_rd),
        .relu_en    (relu_en),
        .frame_len  (frame_len),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // Expected beats for a popped vector: ReLU and frame position from the model
    function automatic void push_vec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          is_last;
        r = v;
        for (int c = 0; c < COL; c++) begin
            if (relu_en && v[PSUM_BW*c + PSUM_BW - 1]) r[PSUM_BW*c +: PSUM_BW] = 16'h0000;
        end
        if (mcnt == 0) mlen = (frame_len == 8'd0) ? 256 : int'(frame_len);
        is_last = (mcnt == mlen - 1);
        for (int b = 0; b < BEATS; b++) begin
            sb.push_back({(b == BEATS - 1) && is_last, r[OUT_BW*b +: OUT_BW]});
        end
        mcnt = is_last ? 0 : mcnt + 1;
    endfunction

    function automatic logic [VW-1:0] ramp_vec(input int base);
        logic [VW-1:0] v;
        for (int c = 0; c < COL; c++) v[PSUM_BW*c +: PSUM_BW] = 16'(base + c + 1);
        return v;
    endfunction

    // Monitor + OFIFO model: check at negedge, update FIFO head just after posedge
    always begin
        logic exp_in_rd;
        @(negedge clk);
        cyc++;
        if (!reset) begin
            chk("m_valid", {63'd0, m_valid}, {63'd0, sb.size() > 0});
            chk("frame_done", {63'd0, frame_done}, {63'd0, exp_fd});
            if (frame_done) nfd++;
            exp_in_rd = in_valid && (sb.size() == 0 || (sb.size() == 1 && m_valid && m_ready));
            chk("in_rd", {63'd0, in_rd}, {63'd0, exp_in_rd});
            exp_fd = 1'b0;
            if (m_valid && sb.size() > 0) begin
                chk("m_data", {32'd0, m_data}, {32'd0, sb[0][OUT_BW-1:0]});
                chk("m_last", {63'd0, m_last}, {63'd0, sb[0][OUT_BW]});
                if (m_ready) begin
                    exp_fd = sb[0][OUT_BW];
                    log_d.push_back(m_data);
                    log_last.push_back(m_last);
                    log_t.push_back(cyc);
                    if (m_last) nlast++;
                    void'(sb.pop_front());
                end
            end
            do_pop = in_rd;
            if (in_rd) push_vec(in_data);
        end
        @(posedge clk);
        #1;
        if (do_pop && fifo.size() > 0) void'(fifo.pop_front());
        do_pop   = 1'b0;
        in_valid = (fifo.size() > 0);
        in_data  = (fifo.size() > 0) ? fifo[0] : {VW{1'b0}};
    end

    task automatic clear_logs();
        log_d.delete();
        log_last.delete();
        log_t.delete();
        nlast = 0;
        nfd   = 0;
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #3;
            if (fifo.size() == 0 && sb.size() == 0 && !m_valid && !in_valid) begin
                done = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        #3;
        chk("idle_timeout", {63'd0, done}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = {VW{1'b0}};
        m_ready   = 1'b1;
        relu_en   = 1'b0;
        frame_len = 8'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_data", {32'd0, m_data}, 64'd0);
        chk("rst_m_last", {63'd0, m_last}, 64'd0);
        chk("rst_in_rd", {63'd0, in_rd}, 64'd0);
        chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single vector, channels 1..8, frame_len=1
        clear_logs();
        fifo.push_back(ramp_vec(0));
        wait_idle(50);
        chk("s1_nbeats", 64'(log_d.size()), 64'd4);
        if (log_d.size() == 4) begin
            chk("s1_beat0", {32'd0, log_d[0]}, 64'h0002_0001);
            chk("s1_beat1", {32'd0, log_d[1]}, 64'h0004_0003);
            chk("s1_beat2", {32'd0, log_d[2]}, 64'h0006_0005);
            chk("s1_beat3", {32'd0, log_d[3]}, 64'h0008_0007);
            chk("s1_last3", {63'd0, log_last[3]}, 64'd1);
        end
        chk("s1_nlast", 64'(nlast), 64'd1);
        chk("s1_nfd", 64'(nfd), 64'd1);

        // ReLU on and off
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            relu_en = (k == 0);
            fifo.push_back({96'd0, 16'h0005, 16'hFFFF});
            wait_idle(50);
            chk("relu_nbeats", 64'(log_d.size()), 64'd4);
            if (log_d.size() > 0)
                chk(k == 0 ? "relu_on_beat0" : "relu_off_beat0", {32'd0, log_d[0]},
                    k == 0 ? 64'h0005_0000 : 64'h0005_FFFF);
        end
        relu_en = 1'b0;

        // Backpressure 1,0,0,1 with two vectors queued
        clear_logs();
        @(posedge clk);
        #2;
        fifo.push_back(ramp_vec(16));
        fifo.push_back(ramp_vec(32));
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #2;
            m_ready = (k % 4 == 0) || (k % 4 == 3);
        end
        m_ready = 1'b1;
        wait_idle(50);
        chk("bp_nbeats", 64'(log_d.size()), 64'd8);
        chk("bp_nfd", 64'(nfd), 64'd2);

        // Three-vector frame, no bubbles
        clear_logs();
        frame_len = 8'd3;
        for (int v = 0; v < 3; v++) fifo.push_back(ramp_vec(100 + 8*v));
        wait_idle(80);
        chk("f3_nbeats", 64'(log_d.size()), 64'd12);
        if (log_d.size() == 12) begin
            chk("f3_contig", 64'(log_t[11] - log_t[0]), 64'd11);
            chk("f3_last11", {63'd0, log_last[11]}, 64'd1);
        end
        chk("f3_nlast", 64'(nlast), 64'd1);
        chk("f3_nfd", 64'(nfd), 64'd1);

        // frame_len=0 means 256 vectors; a mid-frame frame_len change is ignored
        clear_logs();
        frame_len = 8'd0;
        for (int v = 0; v < 256; v++) fifo.push_back({$urandom, $urandom, $urandom, $urandom});
        repeat (100) @(posedge clk);
        #2;
        frame_len = 8'd5;
        wait_idle(2000);
        chk("f256_nbeats", 64'(log_d.size()), 64'd1024);
        if (log_d.size() == 1024) chk("f256_last1023", {63'd0, log_last[1023]}, 64'd1);
        chk("f256_nlast", 64'(nlast), 64'd1);
        chk("f256_nfd", 64'(nfd), 64'd1);

        // Reset during beat 2 of vector 1 in a 2-vector frame
        clear_logs();
        frame_len = 8'd2;
        fifo.push_back(ramp_vec(200));
        fifo.push_back(ramp_vec(208));
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #3;
            if (log_d.size() == 6) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached", {63'd0, ok}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_mid_m_data", {32'd0, m_data}, 64'd0);
        chk("rst_mid_m_last", {63'd0, m_last}, 64'd0);
        chk("rst_mid_in_rd", {63'd0, in_rd}, 64'd0);
        chk("rst_mid_frame_done", {63'd0, frame_done}, 64'd0);
        fifo.delete();
        sb.delete();
        mcnt     = 0;
        exp_fd   = 1'b0;
        do_pop   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        fifo.push_back(ramp_vec(300));
        fifo.push_back(ramp_vec(308));
        wait_idle(60);
        chk("post_rst_nbeats", 64'(log_d.size()), 64'd8);
        if (log_d.size() == 8) begin
            chk("post_rst_last3", {63'd0, log_last[3]}, 64'd0);
            chk("post_rst_last7", {63'd0, log_last[7]}, 64'd1);
        end
        chk("post_rst_nfd", 64'(nfd), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_out_stream_packer
